// File: rtl/burst_mem_responder.sv
// burst_mem_responder: memory-side responder for the 4-beat cacheline burst
// protocol. Holds a line array, waits a fixed latency after accepting a
// request, then streams (read) or collects (write) one line as BEATS beats.
module burst_mem_responder #(
  parameter int unsigned BEAT_WIDTH = 64,
  parameter int unsigned BEATS      = 4,
  parameter int unsigned LINE_IDX_W = 8,
  parameter int unsigned LATENCY    = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           address_i,
  input  logic                  read_i,
  input  logic                  write_i,
  input  logic [BEAT_WIDTH-1:0] burst_i,
  output logic [BEAT_WIDTH-1:0] burst_o,
  output logic                  resp_o,
  output logic                  busy_o,
  output logic                  err_o,
  output logic [31:0]           read_count,
  output logic [31:0]           write_count
);

  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned DEPTH  = 2 ** LINE_IDX_W;

  typedef logic [BEATS-1:0][BEAT_WIDTH-1:0] line_t;
  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  state_t                state_q,   state_d;
  logic [7:0]            lat_cnt_q, lat_cnt_d;
  logic [BEAT_W-1:0]     beat_q,    beat_d;
  logic [LINE_IDX_W-1:0] idx_q,     idx_d;
  logic                  op_wr_q,   op_wr_d;
  line_t                 wbuf_q,    wbuf_d;
  logic [31:0]           rd_cnt_q,  rd_cnt_d;
  logic [31:0]           wr_cnt_q,  wr_cnt_d;

  logic  mem_we;
  logic  req_held;
  logic  last_beat;
  line_t mem [DEPTH];

  // Address bits below the line offset and above the index never matter.
  logic unused_addr;
  assign unused_addr = ^{address_i[31:5+LINE_IDX_W], address_i[4:0]};

  assign req_held  = op_wr_q ? write_i : read_i;
  assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

  // Control and bookkeeping registers; array contents are deliberately not reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      lat_cnt_q <= '0;
      beat_q    <= '0;
      idx_q     <= '0;
      op_wr_q   <= 1'b0;
      wbuf_q    <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      lat_cnt_q <= lat_cnt_d;
      beat_q    <= beat_d;
      idx_q     <= idx_d;
      op_wr_q   <= op_wr_d;
      wbuf_q    <= wbuf_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  // Next-state logic: accept, latency countdown, beat sequencing, abort on dropped request.
  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    beat_d    = beat_q;
    idx_d     = idx_q;
    op_wr_d   = op_wr_q;
    wbuf_d    = wbuf_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    mem_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (read_i ^ write_i) begin
          idx_d     = address_i[5 +: LINE_IDX_W];
          op_wr_d   = write_i;
          lat_cnt_d = 8'(LATENCY - 1);
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (!req_held) begin
          state_d = IDLE;
        end else if (lat_cnt_q == '0) begin
          beat_d  = '0;
          state_d = BURST;
        end else begin
          lat_cnt_d = lat_cnt_q - 8'd1;
        end
      end
      BURST: begin
        if (!req_held) begin
          state_d = IDLE;
        end else begin
          if (op_wr_q) begin
            wbuf_d[beat_q] = burst_i;
          end
          if (last_beat) begin
            // The final beat goes straight from burst_i into the committed line.
            mem_we = op_wr_q;
            if (op_wr_q) begin
              wr_cnt_d = wr_cnt_q + 32'd1;
            end else begin
              rd_cnt_d = rd_cnt_q + 32'd1;
            end
            state_d = DONE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Line array write port: whole line committed on the last write-beat edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[idx_q] <= wbuf_d;
    end
  end

  // Outputs decoded from state so async reset clears them immediately.
  always_comb begin
    burst_o = '0;
    if (state_q == BURST && !op_wr_q) begin
      burst_o = mem[idx_q][beat_q];
    end
  end

  assign resp_o      = (state_q == BURST);
  assign busy_o      = (state_q != IDLE);
  assign err_o       = (state_q == IDLE) && read_i && write_i;
  assign read_count  = rd_cnt_q;
  assign write_count = wr_cnt_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Testbench for burst_mem_responder: directed vector table, hand-written
// corner sequences and randomized bursts checked against a line-array model.
module tb_burst_mem_responder;

  localparam int unsigned BW  = 64;
  localparam int unsigned NB  = 4;
  localparam int unsigned IW  = 8;
  localparam int unsigned LAT = 10;

  typedef logic [NB-1:0][BW-1:0] line_t;

  logic          clk, rst;
  logic [31:0]   address_i;
  logic          read_i, write_i;
  logic [BW-1:0] burst_i, burst_o;
  logic          resp_o, busy_o, err_o;
  logic [31:0]   read_count, write_count;

  burst_mem_responder #(
    .BEAT_WIDTH(BW),
    .BEATS(NB),
    .LINE_IDX_W(IW),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .address_i(address_i),
    .read_i(read_i),
    .write_i(write_i),
    .burst_i(burst_i),
    .burst_o(burst_o),
    .resp_o(resp_o),
    .busy_o(busy_o),
    .err_o(err_o),
    .read_count(read_count),
    .write_count(write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the memory as an array of whole lines plus burst counters.
  line_t       model_mem [2**IW];
  bit          model_valid [2**IW];
  int unsigned m_rc = 0;
  int unsigned m_wc = 0;

  function automatic int unsigned line_of(input logic [31:0] addr);
    return (addr / 32) % (2**IW);
  endfunction

  function automatic void model_commit(input bit wr, input logic [31:0] addr, input line_t wl);
    if (wr) begin
      model_mem[line_of(addr)]   = wl;
      model_valid[line_of(addr)] = 1'b1;
      m_wc++;
    end else begin
      m_rc++;
    end
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drives one request and follows it until resp_o has ended (or the request
  // was withdrawn). lat = negedges after the accepting edge until first resp_o.
  task automatic xfer(input bit wr, input logic [31:0] addr, input line_t wline,
                      input int drop_wait, input int drop_beat, input bit hold_done,
                      output line_t rline, output int lat, output int beats,
                      output bit busy_exit);
    bit dropped, fin, zero_ok;
    rline = '0; lat = -1; beats = 0; busy_exit = 1'b0;
    dropped = 1'b0; fin = 1'b0; zero_ok = 1'b1;
    @(negedge clk);
    address_i = addr; read_i = !wr; write_i = wr; burst_i = wline[0];
    @(posedge clk);
    for (int cyc = 0; cyc < int'(LAT + NB + 16) && !fin; cyc++) begin
      @(negedge clk);
      if (cyc == 0) address_i = $urandom;
      if (!resp_o && (beats > 0 || dropped)) begin
        fin = 1'b1;
        busy_exit = busy_o;
        if (!hold_done) begin
          read_i = 1'b0; write_i = 1'b0;
        end
      end else if (resp_o) begin
        if (lat < 0) lat = cyc;
        if (beats < int'(NB)) begin
          if (wr) begin
            burst_i = wline[beats];
            if (burst_o !== '0) zero_ok = 1'b0;
          end else begin
            rline[beats] = burst_o;
          end
        end
        if (beats == drop_beat) begin
          read_i = 1'b0; write_i = 1'b0; dropped = 1'b1;
        end
        beats++;
      end else begin
        if (burst_o !== '0) zero_ok = 1'b0;
        if (cyc == drop_wait) begin
          read_i = 1'b0; write_i = 1'b0; dropped = 1'b1;
        end
      end
    end
    chk("xfer_completes", fin, 1'b1);
    chk("burst_o_zero_when_no_read_beat", zero_ok, 1'b1);
    if (!fin) begin
      read_i = 1'b0; write_i = 1'b0;
    end
  endtask

  // Runs one transfer and checks it against the reference model.
  task automatic run_check(input bit wr, input logic [31:0] addr, input line_t wline,
                           input int drop_wait, input int drop_beat, input bit hold_done);
    line_t rl;
    int lat, beats;
    bit be, abort;
    abort = (drop_wait >= 0) || (drop_beat >= 0);
    xfer(wr, addr, wline, drop_wait, drop_beat, hold_done, rl, lat, beats, be);
    if (drop_wait >= 0) begin
      chk("beats_after_wait_abort", beats, 0);
    end else begin
      chk("first_resp_latency", lat, LAT);
      chk("beat_count", beats, (drop_beat >= 0) ? drop_beat + 1 : int'(NB));
    end
    chk("busy_at_end", be, !abort);
    if (!abort) begin
      if (!wr && model_valid[line_of(addr)]) chk("read_line", rl, model_mem[line_of(addr)]);
      model_commit(wr, addr, wline);
    end
    chk("read_count", read_count, m_rc);
    chk("write_count", write_count, m_wc);
  endtask

  // Asynchronous reset pulse applied mid-cycle; outputs must clear at once.
  task automatic reset_pulse();
    #2 rst = 1'b1;
    #1;
    chk("rst_resp_o", resp_o, 1'b0);
    chk("rst_busy_o", busy_o, 1'b0);
    chk("rst_burst_o", burst_o, '0);
    chk("rst_err_o", err_o, 1'b0);
    chk("rst_read_count", read_count, '0);
    chk("rst_write_count", write_count, '0);
    @(negedge clk);
    read_i = 1'b0; write_i = 1'b0; burst_i = '0;
    @(negedge clk);
    rst = 1'b0;
    m_rc = 0; m_wc = 0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    line_t       wline;
    line_t       exp_line;
    int          exp_lat;
    int unsigned exp_rc;
    int unsigned exp_wc;
  } vec_t;

  vec_t  vecs [8];
  line_t l1, l2, l3;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    line_t rl;
    int lat, beats;
    bit be, seen;

    l1[0] = 64'h1111_1111_1111_1111; l1[1] = 64'h2222_2222_2222_2222;
    l1[2] = 64'h3333_3333_3333_3333; l1[3] = 64'h4444_4444_4444_4444;
    l2[0] = 64'hA5A5_0000_DEAD_BEEF; l2[1] = 64'h0123_4567_89AB_CDEF;
    l2[2] = 64'hFFFF_FFFF_0000_0001; l2[3] = 64'h5A5A_5A5A_C3C3_C3C3;
    l3[0] = 64'hFEED_FACE_0000_00FF; l3[1] = 64'h8000_0000_0000_0000;
    l3[2] = 64'h0000_0000_0000_0001; l3[3] = 64'h7777_8888_9999_AAAA;

    vecs[0] = '{1'b1, 32'h0000_0040, l1, '0, 10, 0, 1};
    vecs[1] = '{1'b0, 32'h0000_0040, '0, l1, 10, 1, 1};
    vecs[2] = '{1'b0, 32'h0000_2040, '0, l1, 10, 2, 1};
    vecs[3] = '{1'b0, 32'h0000_205F, '0, l1, 10, 3, 1};
    vecs[4] = '{1'b1, 32'h0000_0080, l2, '0, 10, 3, 2};
    vecs[5] = '{1'b0, 32'h0000_009F, '0, l2, 10, 4, 2};
    vecs[6] = '{1'b1, 32'hFFFF_FFE0, l3, '0, 10, 4, 3};
    vecs[7] = '{1'b0, 32'h0000_1FE0, '0, l3, 10, 5, 3};

    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; address_i = '0; burst_i = '0;
    repeat (2) @(negedge clk);
    chk("reset_resp_o", resp_o, 1'b0);
    chk("reset_busy_o", busy_o, 1'b0);
    chk("reset_err_o", err_o, 1'b0);
    chk("reset_burst_o", burst_o, '0);
    chk("reset_read_count", read_count, '0);
    chk("reset_write_count", write_count, '0);
    rst = 1'b0;

    // Directed vectors: write/read, index wrap, ignored offset bits, top index.
    for (int i = 0; i < 8; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wline, -1, -1, 1'b0, rl, lat, beats, be);
      chk("vec_latency", lat, vecs[i].exp_lat);
      chk("vec_beats", beats, NB);
      if (!vecs[i].wr) chk("vec_read_line", rl, vecs[i].exp_line);
      chk("vec_read_count", read_count, vecs[i].exp_rc);
      chk("vec_write_count", write_count, vecs[i].exp_wc);
      model_commit(vecs[i].wr, vecs[i].addr, vecs[i].wline);
    end

    // Both requests high in IDLE: error strobe only, no transfer.
    @(negedge clk);
    read_i = 1'b1; write_i = 1'b1; address_i = 32'h40;
    #1;
    chk("err_pulse_high", err_o, 1'b1);
    chk("err_busy_low", busy_o, 1'b0);
    @(negedge clk);
    chk("err_stays_idle", busy_o, 1'b0);
    read_i = 1'b0; write_i = 1'b0;
    #1;
    chk("err_pulse_ends", err_o, 1'b0);
    seen = 1'b0;
    repeat (LAT + 2) begin
      @(negedge clk);
      if (resp_o || busy_o) seen = 1'b1;
    end
    chk("err_no_transfer", seen, 1'b0);

    // Write to 0x80 withdrawn during beat 2: line keeps l2, count unchanged.
    run_check(1'b1, 32'h0000_0080, l1, -1, 2, 1'b0);
    run_check(1'b0, 32'h0000_0080, '0, -1, -1, 1'b0);
    chk("abort_kept_old_line", model_mem[4], l2);

    // Async reset while waiting, then a fresh read.
    @(negedge clk);
    address_i = 32'h40; read_i = 1'b1;
    @(posedge clk);
    repeat (4) @(negedge clk);
    chk("busy_in_wait", busy_o, 1'b1);
    reset_pulse();
    run_check(1'b0, 32'h0000_0040, '0, -1, -1, 1'b0);

    // Async reset in the middle of a write burst: line must be untouched.
    @(negedge clk);
    address_i = 32'h40; write_i = 1'b1; burst_i = 64'hBAD0_BAD0_BAD0_BAD0;
    @(posedge clk);
    repeat (LAT + 3) @(negedge clk);
    chk("resp_mid_write", resp_o, 1'b1);
    reset_pulse();
    run_check(1'b0, 32'h0000_0040, '0, -1, -1, 1'b0);

    // Back-to-back reads with the request held through DONE.
    run_check(1'b0, 32'h0000_0040, '0, -1, -1, 1'b1);
    run_check(1'b0, 32'h0000_0080, '0, -1, -1, 1'b1);
    run_check(1'b0, 32'h0000_0040, '0, -1, -1, 1'b0);

    // Randomized traffic over a few lines, with occasional aborts.
    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      line_t wl;
      int r, dw, db;
      bit wr, hold;
      a = $urandom;
      a[12:5] = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
      for (int b = 0; b < int'(NB); b++) wl[b] = {$urandom, $urandom};
      r  = $urandom_range(0, 9);
      dw = (r == 0) ? $urandom_range(0, LAT - 1) : -1;
      db = (r == 1) ? $urandom_range(0, NB - 1) : -1;
      wr = 1'($urandom_range(0, 1));
      hold = (r > 1) && ($urandom_range(0, 3) == 0);
      run_check(wr, a, wl, dw, db, hold);
    end

    @(negedge clk);
    read_i = 1'b0; write_i = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
